// File: rtl/iomem_block_bridge.sv
// Line-to-word bridge: splits each 128-bit iomem line request into NBEATS narrow bus beats.
// Optional macro IOMEM_SKIP_EMPTY_BEATS_EN: write beats with an all-zero strobe slice are not issued.
module iomem_block_bridge #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128,
    parameter int BUS_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iomem_valid_i,
    output logic                  iomem_ready_o,
    input  logic [XLEN-1:0]       iomem_addr_i,
    input  logic [BLK_SIZE/8-1:0] iomem_wstrb_i,
    input  logic [BLK_SIZE-1:0]   iomem_wdata_i,
    output logic [BLK_SIZE-1:0]   iomem_rdata_o,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic                  bus_we_o,
    output logic [XLEN-1:0]       bus_addr_o,
    output logic [BUS_W/8-1:0]    bus_wstrb_o,
    output logic [BUS_W-1:0]      bus_wdata_o,
    input  logic [BUS_W-1:0]      bus_rdata_i
);
    localparam int NBEATS = BLK_SIZE / BUS_W;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int BYTE_W = $clog2(BUS_W / 8);
    localparam int OFF_W  = CNT_W + BYTE_W;
    localparam int SW     = BUS_W / 8;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t                    state, state_nx;
    logic [CNT_W-1:0]          cnt;
    logic [XLEN-OFF_W-1:0]     base;
    logic [BLK_SIZE-1:0]       wdata;
    logic [BLK_SIZE-1:0]       rdata;
    logic [BLK_SIZE/8-1:0]     wstrb;
    logic                      is_wr;
    logic                      last, skip, fire, advance;
    logic [SW-1:0]             strb_slice;
    logic [$clog2(BLK_SIZE)-1:0]   bit_ofs;
    logic [$clog2(BLK_SIZE/8)-1:0] strb_ofs;
    logic                      unused_addr;

    // Line offset bits are dropped; beat addresses are composed, so they never carry out of the line.
    assign unused_addr = ^iomem_addr_i[OFF_W-1:0];

    assign bit_ofs    = {cnt, {$clog2(BUS_W){1'b0}}};
    assign strb_ofs   = {cnt, {BYTE_W{1'b0}}};
    assign strb_slice = wstrb[strb_ofs +: SW];
    assign last       = (cnt == CNT_W'(NBEATS - 1));

`ifdef IOMEM_SKIP_EMPTY_BEATS_EN
    assign skip = (state == BEAT) && is_wr && (strb_slice == '0);
`else
    assign skip = 1'b0;
`endif

    assign fire    = bus_valid_o && bus_ready_i;
    assign advance = fire || skip;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (iomem_valid_i) state_nx = BEAT;
            BEAT:    if (advance && last) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        iomem_ready_o = 1'b0;
        bus_valid_o   = 1'b0;
        bus_we_o      = 1'b0;
        bus_addr_o    = '0;
        bus_wstrb_o   = '0;
        bus_wdata_o   = '0;
        case (state)
            BEAT: begin
                bus_valid_o = !skip;
                bus_we_o    = is_wr;
                bus_addr_o  = {base, cnt, {BYTE_W{1'b0}}};
                bus_wstrb_o = is_wr ? strb_slice : '0;
                bus_wdata_o = wdata[bit_ofs +: BUS_W];
            end
            RESP:    iomem_ready_o = 1'b1;
            default: ;
        endcase
    end

    // Request fields are latched at accept so the requester may change its inputs afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            base  <= '0;
            wdata <= '0;
            wstrb <= '0;
            is_wr <= 1'b0;
            rdata <= '0;
        end else begin
            if (state == IDLE && iomem_valid_i) begin
                base  <= iomem_addr_i[XLEN-1:OFF_W];
                wdata <= iomem_wdata_i;
                wstrb <= iomem_wstrb_i;
                is_wr <= |iomem_wstrb_i;
                cnt   <= '0;
            end
            if (fire && !is_wr) rdata[bit_ofs +: BUS_W] <= bus_rdata_i;
            if (advance && !last) cnt <= cnt + 1'b1;
        end
    end

    assign iomem_rdata_o = rdata;
endmodule

// File: tb/tb_iomem_block_bridge.sv
// Scoreboard bench for iomem_block_bridge: stimulus pushes expected beats/responses, a monitor pops and compares.
module tb_iomem_block_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic         iomem_valid;
    logic         iomem_ready;
    logic [31:0]  iomem_addr;
    logic [15:0]  iomem_wstrb;
    logic [127:0] iomem_wdata;
    logic [127:0] iomem_rdata;
    logic         bus_valid;
    logic         bus_ready;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [3:0]   bus_wstrb;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;

    iomem_block_bridge dut (
        .clk_i(clk), .rst_i(rst),
        .iomem_valid_i(iomem_valid), .iomem_ready_o(iomem_ready),
        .iomem_addr_i(iomem_addr), .iomem_wstrb_i(iomem_wstrb),
        .iomem_wdata_i(iomem_wdata), .iomem_rdata_o(iomem_rdata),
        .bus_valid_o(bus_valid), .bus_ready_i(bus_ready), .bus_we_o(bus_we),
        .bus_addr_o(bus_addr), .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] data; int cyc; } beat_t;
    typedef struct { logic [127:0] rd; int cyc; } resp_t;

    localparam logic [127:0] L1    = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LSTL  = 128'hB7910C26_B7910C22_B7910C2E_B7910C2A;
    localparam logic [127:0] LWRAP = 128'h5A5AA5A6_5A5AA5A2_5A5AA5AE_5A5AA5AA;

    beat_t bq[$];
    resp_t rq[$];
    beat_t ex[4];
    int    nb;
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    tout_cnt;
    bit    done;
    logic  rst_edge;
    logic [1:0] stall_at;
    int    stall_len;
    int    stall_cnt = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    // Slave: line 0x8000_0010 returns 0x11111111*(word+1); any other word returns addr ^ 0xA5A55A5A.
    function automatic logic [31:0] slave_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000001) return 32'h11111111 * ({30'd0, a[3:2]} + 32'd1);
        return a ^ 32'hA5A5_5A5A;
    endfunction
    assign bus_rdata = slave_word(bus_addr);

    always @(negedge clk) begin
        if (bus_valid && bus_addr[3:2] == stall_at && stall_cnt < stall_len) begin
            bus_ready = 1'b0;
            stall_cnt++;
        end else begin
            bus_ready = 1'b1;
            if (!bus_valid) stall_cnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor
    logic        prev_stall = 1'b0;
    logic [68:0] prev_bus;
    always @(negedge clk) begin
        #1;
        if (rst_edge === 1'b1) begin
            chk("reset_bus", {iomem_ready, bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata}, '0);
            chk("reset_rdata", iomem_rdata, '0);
        end else if (prev_stall) begin
            chk("stall_hold", {bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata}, {1'b1, prev_bus});
        end
        if (bus_valid && bus_ready) begin
            if (bq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_beat: got addr %h expected no beat", bus_addr);
            end else begin
                beat_t b;
                b = bq.pop_front();
                chk("beat_addr", bus_addr, b.addr);
                chk("beat_we", bus_we, b.we);
                chk("beat_wstrb", bus_wstrb, b.strb);
                if (b.we) chk("beat_wdata", bus_wdata, b.data);
                chk("beat_cycle", cyc, b.cyc);
            end
        end
        if (iomem_ready) begin
            if (rq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
            end else begin
                resp_t r;
                r = rq.pop_front();
                chk("resp_rdata", iomem_rdata, r.rd);
                chk("resp_cycle", cyc, r.cyc);
            end
        end
        prev_stall = bus_valid && !bus_ready;
        prev_bus   = {bus_we, bus_addr, bus_wstrb, bus_wdata};
        if (done) begin
            chk("beats_left", bq.size(), 0);
            chk("resps_left", rq.size(), 0);
            chk("timeouts", tout_cnt, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic beat(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d, input int rel);
        ex[nb] = '{addr: a, we: we, strb: s, data: d, cyc: rel};
        nb++;
    endtask

    task automatic push_exp(input int c0);
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            b = ex[i];
            b.cyc = b.cyc + c0;
            bq.push_back(b);
        end
        nb = 0;
    endtask

    // Issue one line request starting in the next cycle; expects the DUT to be IDLE then.
    task automatic req(input logic [31:0] a, input logic [15:0] s, input logic [127:0] d,
                       input logic [127:0] rd, input int lat);
        int c0;
        @(negedge clk); #1;
        c0 = cyc;
        push_exp(c0);
        rq.push_back('{rd: rd, cyc: c0 + lat});
        iomem_addr = a; iomem_wstrb = s; iomem_wdata = d; iomem_valid = 1'b1;
        @(negedge clk); #1;
        iomem_addr = ~a; iomem_wstrb = ~s; iomem_wdata = ~d;
        for (int k = 0; k < 40 && !iomem_ready; k++) begin @(negedge clk); #1; end
        if (!iomem_ready) begin
            tout_cnt++;
            $display("FAIL ready_timeout: got no ready expected ready at cycle %0d", c0 + lat);
        end
        iomem_valid = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1; iomem_valid = 1'b0; iomem_addr = '0; iomem_wstrb = '0; iomem_wdata = '0;
        stall_at = 2'd0; stall_len = 0; done = 1'b0; tout_cnt = 0; nb = 0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Plain read
        for (int i = 0; i < 4; i++) beat(32'h8000_0010 + 4 * i, 1'b0, 4'h0, 32'h0, i + 1);
        req(32'h8000_0010, 16'h0000, '0, L1, 5);
        idle(2);

        // Full write, low address bits ignored
        beat(32'h8000_0020, 1'b1, 4'hF, 32'hAAAAAAAA, 1);
        beat(32'h8000_0024, 1'b1, 4'hF, 32'hBBBBBBBB, 2);
        beat(32'h8000_0028, 1'b1, 4'hF, 32'hCCCCCCCC, 3);
        beat(32'h8000_002C, 1'b1, 4'hF, 32'hDDDDDDDD, 4);
        req(32'h8000_002C, 16'hFFFF, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, L1, 5);
        idle(2);

        // Read with 3 wait cycles on beat 1
        stall_at = 2'd1; stall_len = 3;
        beat(32'h1234_5670, 1'b0, 4'h0, 32'h0, 1);
        beat(32'h1234_5674, 1'b0, 4'h0, 32'h0, 5);
        beat(32'h1234_5678, 1'b0, 4'h0, 32'h0, 6);
        beat(32'h1234_567C, 1'b0, 4'h0, 32'h0, 7);
        req(32'h1234_5670, 16'h0000, '0, LSTL, 8);
        stall_len = 0;
        idle(2);

        // Sparse write, strobes only on word 1
`ifdef IOMEM_SKIP_EMPTY_BEATS_EN
        beat(32'h4000_0004, 1'b1, 4'hF, 32'h01010101, 2);
`else
        beat(32'h4000_0000, 1'b1, 4'h0, 32'h00000000, 1);
        beat(32'h4000_0004, 1'b1, 4'hF, 32'h01010101, 2);
        beat(32'h4000_0008, 1'b1, 4'h0, 32'h02020202, 3);
        beat(32'h4000_000C, 1'b1, 4'h0, 32'h03030303, 4);
`endif
        req(32'h4000_0000, 16'h00F0, 128'h03030303_02020202_01010101_00000000, LSTL, 5);
        idle(2);

        // Top-of-memory line: beat addresses must not carry out of the line
        for (int i = 0; i < 4; i++) beat(32'hFFFF_FFF0 + 4 * i, 1'b0, 4'h0, 32'h0, i + 1);
        req(32'hFFFF_FFF7, 16'h0000, '0, LWRAP, 5);
        idle(2);

        // Reset during beat 2 of a read: no completion pulse, outputs cleared
        for (int i = 0; i < 3; i++) beat(32'h1234_5670 + 4 * i, 1'b0, 4'h0, 32'h0, i + 1);
        @(negedge clk); #1;
        c0 = cyc;
        push_exp(c0);
        iomem_addr = 32'h1234_5670; iomem_wstrb = '0; iomem_wdata = '0; iomem_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (bus_valid && bus_addr[3:2] == 2'd2) break;
        end
        if (!(bus_valid && bus_addr[3:2] == 2'd2)) begin
            tout_cnt++;
            $display("FAIL beat2_timeout: got no beat 2 expected beat 2 at cycle %0d", c0 + 3);
        end
        rst = 1'b1; iomem_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        idle(3);
        for (int i = 0; i < 4; i++) beat(32'h8000_0010 + 4 * i, 1'b0, 4'h0, 32'h0, i + 1);
        req(32'h8000_0010, 16'h0000, '0, L1, 5);
        idle(2);

        // Back-to-back write then read
`ifdef IOMEM_SKIP_EMPTY_BEATS_EN
        beat(32'h2000_0010, 1'b1, 4'hF, 32'hF1F1F1F1, 1);
        beat(32'h2000_001C, 1'b1, 4'hF, 32'hF4F4F4F4, 4);
`else
        beat(32'h2000_0010, 1'b1, 4'hF, 32'hF1F1F1F1, 1);
        beat(32'h2000_0014, 1'b1, 4'h0, 32'hF2F2F2F2, 2);
        beat(32'h2000_0018, 1'b1, 4'h0, 32'hF3F3F3F3, 3);
        beat(32'h2000_001C, 1'b1, 4'hF, 32'hF4F4F4F4, 4);
`endif
        req(32'h2000_0010, 16'hF00F, 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1, L1, 5);
        for (int i = 0; i < 4; i++) beat(32'h8000_0010 + 4 * i, 1'b0, 4'h0, 32'h0, i + 1);
        req(32'h8000_0010, 16'h0000, '0, L1, 5);

        idle(3);
        done = 1'b1;
    end
endmodule
